demux_8_router: RTL

Eight-way write router for the datapath: accepts one DATA_WIDTH word plus a 3-bit selector per handshake and delivers it to exactly one of eight destination channels, each buffered by a 2-entry FIFO with its own valid/ready handshake. It is the distribution counterpart of the 8-input selection mux. It sits between a single producer, such as the ALU/memory result path, and up to eight independent consumers, such as register banks or special registers.

---
 rtl/demux_8_router_pkg.sv | 12 +
 rtl/demux_chan_fifo.sv | 57 +++++
 rtl/demux_8_router.sv | 75 +++++++
 3 files changed

// File: rtl/demux_8_router_pkg.sv
// Shared constants and types for the eight-way write router (demux_8_router).
package demux8_pkg;

    localparam int NUM_CHANNELS = 8;
    localparam int SEL_WIDTH    = 3;
    localparam int FIFO_DEPTH   = 2;

    typedef logic [1:0] count_t;

    localparam count_t COUNT_FULL = count_t'(FIFO_DEPTH);

endpackage

// File: rtl/demux_chan_fifo.sv
// Two-entry per-channel FIFO: head register plus one overflow slot, order preserved.
module demux_chan_fifo
    import demux8_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output count_t                count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    count_t                cnt_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (cnt_q == COUNT_FULL);
    assign empty   = (cnt_q == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Push+pop can only coincide at count 1 (push is gated by full), so the new word takes the head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= din;
                    else               tail_q <= din;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    head_q <= din;
                end
                default: ;
            endcase
        end
    end

    assign head  = head_q;
    assign count = cnt_q;

endmodule

// File: rtl/demux_8_router.sv
// Eight-way write router: one producer, eight 2-deep buffered consumer channels.
// Optional broadcast write to all channels is enabled by defining DEMUX8_BROADCAST_EN.
module demux_8_router
    import demux8_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [SEL_WIDTH-1:0]               selector,
    input  logic [DATA_WIDTH-1:0]              data_input,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CHANNELS-1:0]            out_valid,
    input  logic [NUM_CHANNELS-1:0]            out_ready
`ifdef DEMUX8_BROADCAST_EN
    ,
    input  logic                               bcast
`endif
);

    logic [NUM_CHANNELS-1:0] push;
    logic [NUM_CHANNELS-1:0] full;
    logic [NUM_CHANNELS-1:0] empty;
    count_t                  chan_count [NUM_CHANNELS];
    logic                    accept;

    // in_ready looks only at registered fullness, never at out_ready.
`ifdef DEMUX8_BROADCAST_EN
    assign in_ready = bcast ? ~|full : !full[selector];
`else
    assign in_ready = !full[selector];
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        push = '0;
        if (accept) begin
`ifdef DEMUX8_BROADCAST_EN
            if (bcast) push = '1;
            else       push[selector] = 1'b1;
`else
            push[selector] = 1'b1;
`endif
        end
    end

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
        demux_chan_fifo #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_fifo (
            .clk    (clk),
            .reset_n(reset_n),
            .push   (push[k]),
            .pop    (out_ready[k]),
            .din    (data_input),
            .head   (out_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .count  (chan_count[k]),
            .full   (full[k]),
            .empty  (empty[k])
        );
    end

    assign out_valid = ~empty;

    // Occupancy counts are kept visible for debug probing; the datapath uses full/empty.
    logic unused_counts;
    always_comb begin
        unused_counts = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) unused_counts = unused_counts ^ (^chan_count[k]);
    end

endmodule
